puf_challenge_driver: RTL

PUF_CHALLENGE_DRIVER -- requirements
Module: puf_challenge_driver

---
 rtl/puf_challenge_driver.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/puf_challenge_driver.sv
// Arbiter-PUF challenge sequencer: launches races, samples the arbiter, packs response words.
// Optional majority voting per challenge is enabled with `define PUF_MAJORITY_VOTE_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_i; challenge loaded from seed on start
// SETUP   | one cycle with race pair low, challenge settled
// LAUNCH  | race pair high for SETTLE_CYCLES cycles
// SAMPLE  | one cycle; synchronized arbiter output captured
// RECOVER | race pair low for SETTLE_CYCLES; challenge may advance on exit
// OUTPUT  | word valid, held until resp_ready_i
module puf_challenge_driver #(
    parameter int             N             = 64,
    parameter int             RESP_BITS     = 32,
    parameter int             SETTLE_CYCLES = 8,
    parameter logic [N-1:0]   TAPS          = N'(64'hD800_0000_0000_0000),
    parameter int             VOTES         = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [N-1:0]         seed_i,
    output logic [1:0]           race_signal_o,
    output logic [N-1:0]         challenge_o,
    input  logic                 response_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [RESP_BITS-1:0] resp_data_o,
    output logic                 busy_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_LAUNCH  = 3'd2;
    localparam logic [2:0] S_SAMPLE  = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;
    localparam logic [2:0] S_OUTPUT  = 3'd5;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_BITS - 1);

    logic [2:0]    state;
    logic [CW-1:0] settle_cnt;
    logic [BW-1:0] bit_idx;
    logic [1:0]    resp_sync;
    logic          sample;
    logic          last_vote;
    logic          bit_value;
    logic [N-1:0]  challenge_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_sync <= 2'b00;
        end else begin
            resp_sync <= {resp_sync[0], response_i};
        end
    end

    assign sample         = resp_sync[1];
    assign challenge_next = {challenge_o[N-2:0], ^(challenge_o & TAPS)};
    assign race_signal_o  = ((state == S_LAUNCH) || (state == S_SAMPLE)) ? 2'b11 : 2'b00;
    assign busy_o         = (state != S_IDLE);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VW = $clog2(VOTES + 1);
    localparam logic [VW:0]   HALF      = (VW + 1)'(VOTES / 2);
    localparam logic [VW-1:0] LAST_VOTE = VW'(VOTES - 1);

    logic [VW-1:0] vote_idx;
    logic [VW-1:0] ones_cnt;
    logic [VW:0]   ones_total;

    assign ones_total = {1'b0, ones_cnt} + {{VW{1'b0}}, sample};
    assign bit_value  = (ones_total > HALF);
    assign last_vote  = (vote_idx == LAST_VOTE);

    // Vote bookkeeping: tallies reset on start and after each bit's final sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vote_idx <= '0;
            ones_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        vote_idx <= '0;
                        ones_cnt <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (last_vote) begin
                        ones_cnt <= '0;
                    end else begin
                        ones_cnt <= ones_total[VW-1:0];
                    end
                end
                S_RECOVER: begin
                    if (settle_cnt == '0) begin
                        vote_idx <= last_vote ? '0 : vote_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign bit_value = sample;
    assign last_vote = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            bit_idx      <= '0;
            challenge_o  <= '0;
            resp_data_o  <= '0;
            resp_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        challenge_o <= (seed_i == '0) ? N'(1) : seed_i;
                        bit_idx     <= '0;
                        resp_data_o <= '0;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    if (settle_cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (last_vote) begin
                        resp_data_o[bit_idx] <= bit_value;
                    end
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_RECOVER;
                end
                S_RECOVER: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else if (!last_vote) begin
                        state <= S_SETUP;
                    end else begin
                        // Challenge only moves here, while the race pair is low.
                        challenge_o <= challenge_next;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_OUTPUT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= S_SETUP;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (!resp_valid_o) begin
                        resp_valid_o <= 1'b1;
                    end else if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
